// File: rtl/bus_gen_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bus_gen_arbiter
// Brief   : Round-robin shared-bus arbiter between show-ahead driver FIFOs and
//           terminal inputs. Optional macro BCAST_INCL_SRC_EN makes broadcast
//           also deliver to the source terminal.
// Revision: 1.0
// ============================================================================
module bus_gen_arbiter #(
    parameter int         BITS      = 1,
    parameter int         DRVRS     = 4,
    parameter int         PCKG_SZ   = 16,
    parameter logic [7:0] BROADCAST = 8'hFF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BITS*DRVRS-1:0]         pndng,
    input  logic [BITS*DRVRS*PCKG_SZ-1:0] D_pop,
    output logic [BITS*DRVRS-1:0]         pop,
    output logic [BITS*DRVRS-1:0]         push,
    output logic [BITS*DRVRS*PCKG_SZ-1:0] D_push
);

    localparam int c_PW = (DRVRS > 1) ? $clog2(DRVRS) : 1;
    localparam int c_SW = c_PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_PUSH = 2'd2
    } state_t;

    for (genvar b = 0; b < BITS; b++) begin : g_slice
        state_t              r_state, w_state_nxt;
        logic [c_PW-1:0]     r_src, w_src_nxt;
        logic [c_PW-1:0]     r_rr_ptr, w_rr_ptr_nxt;
        logic [PCKG_SZ-1:0]  r_pkt, w_pkt_nxt;
        logic [DRVRS-1:0]    r_pop, w_pop_nxt;
        logic [DRVRS-1:0]    r_push, w_push_nxt;
        logic [DRVRS-1:0]    w_pndng;
        logic [PCKG_SZ-1:0]  w_dpop [DRVRS];
        logic [7:0]          w_dest;
        logic                w_found;
        logic [c_PW-1:0]     w_grant;
        logic [c_SW-1:0]     w_sum;

        assign w_pndng = pndng[b*DRVRS +: DRVRS];
        assign pop[b*DRVRS +: DRVRS]  = r_pop;
        assign push[b*DRVRS +: DRVRS] = r_push;

        for (genvar t = 0; t < DRVRS; t++) begin : g_term
            assign w_dpop[t] = D_pop[(b*DRVRS+t)*PCKG_SZ +: PCKG_SZ];
            assign D_push[(b*DRVRS+t)*PCKG_SZ +: PCKG_SZ] = r_pkt;
        end

        assign w_dest = w_dpop[r_src][PCKG_SZ-1 -: 8];

        // First pending terminal at or after rr_ptr, wrapping modulo DRVRS.
        always_comb begin
            w_found = 1'b0;
            w_grant = '0;
            w_sum   = '0;
            for (int k = 0; k < DRVRS; k++) begin
                w_sum = {1'b0, r_rr_ptr} + c_SW'(k);
                if (w_sum >= c_SW'(DRVRS)) begin
                    w_sum = w_sum - c_SW'(DRVRS);
                end
                if (!w_found && w_pndng[w_sum[c_PW-1:0]]) begin
                    w_found = 1'b1;
                    w_grant = w_sum[c_PW-1:0];
                end
            end
        end

        always_comb begin
            w_state_nxt  = r_state;
            w_src_nxt    = r_src;
            w_rr_ptr_nxt = r_rr_ptr;
            w_pkt_nxt    = r_pkt;
            w_pop_nxt    = '0;
            w_push_nxt   = '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        w_src_nxt          = w_grant;
                        w_pop_nxt[w_grant] = 1'b1;
                        w_state_nxt        = ST_POP;
                    end
                end
                ST_POP: begin
                    // Show-ahead data is still valid while pop is high.
                    w_pkt_nxt    = w_dpop[r_src];
                    w_rr_ptr_nxt = (r_src == c_PW'(DRVRS-1)) ? '0 : r_src + 1'b1;
                    if (int'(w_dest) < DRVRS) begin
                        w_push_nxt[w_dest[c_PW-1:0]] = 1'b1;
                    end else if (w_dest == BROADCAST) begin
                        w_push_nxt = '1;
`ifndef BCAST_INCL_SRC_EN
                        w_push_nxt[r_src] = 1'b0;
`endif
                    end
                    w_state_nxt = ST_PUSH;
                end
                ST_PUSH: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_state  <= ST_IDLE;
                r_src    <= '0;
                r_rr_ptr <= '0;
                r_pkt    <= '0;
                r_pop    <= '0;
                r_push   <= '0;
            end else begin
                r_state  <= w_state_nxt;
                r_src    <= w_src_nxt;
                r_rr_ptr <= w_rr_ptr_nxt;
                r_pkt    <= w_pkt_nxt;
                r_pop    <= w_pop_nxt;
                r_push   <= w_push_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_gen_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_gen_arbiter
// Brief   : Directed self-checking bench for bus_gen_arbiter (1 slice, 4 terms).
// Revision: 1.0
// ============================================================================
module tb_bus_gen_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  pndng;
    logic [63:0] D_pop;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [63:0] D_push;

    int n_checks = 0;
    int n_errors = 0;

    bus_gen_arbiter #(
        .BITS     (1),
        .DRVRS    (4),
        .PCKG_SZ  (16),
        .BROADCAST(8'hFF)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (D_pop),
        .pop    (pop),
        .push   (push),
        .D_push (D_push)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int lane, input logic [15:0] pkt);
        D_pop[lane*16 +: 16] = pkt;
    endtask

    // One complete IDLE->POP->PUSH->IDLE transaction from a single source.
    task automatic run_pkt(input string tag, input int src, input logic [15:0] pkt,
                           input logic [3:0] exp_push);
        pndng = 4'b0001 << src;
        set_lane(src, pkt);
        step();
        chk({tag, "_pop"}, 64'(pop), 64'(4'b0001 << src));
        chk({tag, "_nopush"}, 64'(push), 64'd0);
        pndng = 4'b0000;
        step();
        chk({tag, "_popclr"}, 64'(pop), 64'd0);
        chk({tag, "_push"}, 64'(push), 64'(exp_push));
        chk({tag, "_dpush"}, D_push, {4{pkt}});
        step();
        chk({tag, "_pushclr"}, 64'(push), 64'd0);
        chk({tag, "_dhold"}, D_push, {4{pkt}});
    endtask

    logic [3:0] bcast_exp;

    initial begin
        reset = 1'b0;
        pndng = 4'b1111;
        D_pop = {16'h0111, 16'h0222, 16'h0333, 16'h0044};
`ifdef BCAST_INCL_SRC_EN
        bcast_exp = 4'b1111;
`else
        bcast_exp = 4'b0111;
`endif

        for (int i = 0; i < 25; i++) begin
            step();
            chk("rst_pop", 64'(pop), 64'd0);
            chk("rst_push", 64'(push), 64'd0);
            chk("rst_dpush", D_push, 64'd0);
        end
        reset = 1'b1;
        pndng = 4'b0000;
        step();
        chk("idle_pop", 64'(pop), 64'd0);

        run_pkt("uni", 1, 16'h02AB, 4'b0100);
        run_pkt("bcast", 3, 16'hFF5A, bcast_exp);
        run_pkt("inval", 0, 16'h07CC, 4'b0000);
        run_pkt("after_inval", 2, 16'h0155, 4'b0010);

        // Reset during POP drops the packet and rewinds rr_ptr.
        pndng = 4'b0100;
        set_lane(2, 16'h0011);
        step();
        chk("midrst_pop", 64'(pop), 64'(4'b0100));
        reset = 1'b0;
        pndng = 4'b1111;
        for (int i = 0; i < 4; i++) set_lane(i, {8'((i + 1) % 4), 8'(8'hA0 + i)});
        step();
        chk("midrst_popclr", 64'(pop), 64'd0);
        chk("midrst_push", 64'(push), 64'd0);
        chk("midrst_dpush", D_push, 64'd0);
        reset = 1'b1;

        for (int g = 0; g < 5; g++) begin
            step();
            chk("rr_pop", 64'(pop), 64'(4'b0001 << (g % 4)));
            chk("rr_nopush", 64'(push), 64'd0);
            step();
            chk("rr_popclr", 64'(pop), 64'd0);
            chk("rr_push", 64'(push), 64'(4'b0001 << ((g + 1) % 4)));
            chk("rr_dpush", D_push[15:0], 64'({8'((g % 4 + 1) % 4), 8'(8'hA0 + g % 4)}));
            step();
            chk("rr_gap_pop", 64'(pop), 64'd0);
            chk("rr_gap_push", 64'(push), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
